// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath. It sequences fetch, decode,
// execute, memory and writeback, and stalls while memory reports not-ready.
module multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    OP,
  input  logic [OP_WIDTH-1:0]    Funct,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSource,
  output logic                   Illegal,
  output logic [3:0]             State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [OP_WIDTH-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OP_WIDTH-1:0] OPC_J     = 6'h02;
  localparam logic [OP_WIDTH-1:0] OPC_JAL   = 6'h03;
  localparam logic [OP_WIDTH-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OP_WIDTH-1:0] OPC_BNE   = 6'h05;
  localparam logic [OP_WIDTH-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OP_WIDTH-1:0] OPC_ANDI  = 6'h0c;
  localparam logic [OP_WIDTH-1:0] OPC_ORI   = 6'h0d;
  localparam logic [OP_WIDTH-1:0] OPC_LUI   = 6'h0f;
  localparam logic [OP_WIDTH-1:0] OPC_LW    = 6'h23;
  localparam logic [OP_WIDTH-1:0] OPC_SW    = 6'h2b;
  localparam logic [OP_WIDTH-1:0] FN_JR     = 6'h08;

  localparam logic [ALUOP_WIDTH-1:0] AOP_SUB  = 3'b001;
  localparam logic [ALUOP_WIDTH-1:0] AOP_ADD  = 3'b010;
  localparam logic [ALUOP_WIDTH-1:0] AOP_LUI  = 3'b011;
  localparam logic [ALUOP_WIDTH-1:0] AOP_ADDI = 3'b100;
  localparam logic [ALUOP_WIDTH-1:0] AOP_ORI  = 3'b101;
  localparam logic [ALUOP_WIDTH-1:0] AOP_ANDI = 3'b110;
  localparam logic [ALUOP_WIDTH-1:0] AOP_R    = 3'b111;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = '0;
    PCSource = 2'd0;
    Illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = AOP_ADD;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        ALUSrcB = 2'd3;
        ALUOp   = AOP_ADD;
        case (OP)
          OPC_LW, OPC_SW:                       state_d = S_MEMADR;
          OPC_RTYPE:                            state_d = (Funct == FN_JR) ? S_JR : S_RTEXE;
          OPC_ADDI, OPC_ORI, OPC_ANDI, OPC_LUI: state_d = S_IEXE;
          OPC_BEQ, OPC_BNE:                     state_d = S_BRANCH;
          OPC_J:                                state_d = S_JUMP;
          OPC_JAL:                              state_d = S_JAL;
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp   = AOP_ADD;
        state_d = (OP == OPC_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_RTEXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = AOP_R;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
        state_d  = S_FETCH;
      end
      S_IEXE: begin
        // IR is held, so OP still names the immediate instruction.
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (OP)
          OPC_ORI:  ALUOp = AOP_ORI;
          OPC_ANDI: ALUOp = AOP_ANDI;
          OPC_LUI:  ALUOp = AOP_LUI;
          default:  ALUOp = AOP_ADDI;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = AOP_SUB;
        PCSource = 2'd1;
        PCWrite  = ((OP == OPC_BEQ) && Zero) || ((OP == OPC_BNE) && !Zero);
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        // PC already holds the return address (PC+4) from FETCH.
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd2;
        state_d  = S_FETCH;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'd3;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are forced quiet while reset is held so no access can complete.
    if (!reset) begin
      state_d  = S_FETCH;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 2'd0;
      MemtoReg = 2'd0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      ALUOp    = '0;
      PCSource = 2'd0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table of expected controls,
// checked through a scoreboard queue, plus reset-during-store sequence.
module tb_multicycle_control;

  logic       clk, reset;
  logic [5:0] OP, Funct;
  logic       Zero, MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;

  multicycle_control #(.OP_WIDTH(6), .ALUOP_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] act;
  assign act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  int vec_cnt  = 0;
  int miss_cnt = 0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        r;
    logic [22:0] exp;
    string       nm;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];
  string       name_q[$];

  logic watch   = 1'b0;
  logic mw_seen = 1'b0;
  always @(posedge clk or negedge clk) if (watch && MemWrite) mw_seen = 1'b1;

  function automatic logic [22:0] mk(input logic [3:0] st, input logic pcw, iord, mr, mw, irw,
                                     input logic [1:0] rd, m2r, input logic rw, sa,
                                     input logic [1:0] sb, input logic [2:0] aop,
                                     input logic [1:0] pcs, input logic ill);
    return {st, pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, ill};
  endfunction

  function automatic logic [22:0] e_fetch(input logic r);
    return mk(4'd0, r, 0, 1, 0, r, 2'd0, 2'd0, 0, 0, 2'd1, 3'b010, 2'd0, 0);
  endfunction
  function automatic logic [22:0] e_dec(input logic il);
    return mk(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 3'b010, 2'd0, il);
  endfunction
  function automatic logic [22:0] e_ma();   return mk(4'd2, 0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, 3'b010, 2'd0, 0); endfunction
  function automatic logic [22:0] e_mr();   return mk(4'd3, 0,1,1,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'b000, 2'd0, 0); endfunction
  function automatic logic [22:0] e_mwb();  return mk(4'd4, 0,0,0,0,0, 2'd0,2'd1, 1,0, 2'd0, 3'b000, 2'd0, 0); endfunction
  function automatic logic [22:0] e_mw();   return mk(4'd5, 0,1,0,1,0, 2'd0,2'd0, 0,0, 2'd0, 3'b000, 2'd0, 0); endfunction
  function automatic logic [22:0] e_rte();  return mk(4'd6, 0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd0, 3'b111, 2'd0, 0); endfunction
  function automatic logic [22:0] e_rtwb(); return mk(4'd7, 0,0,0,0,0, 2'd1,2'd0, 1,0, 2'd0, 3'b000, 2'd0, 0); endfunction
  function automatic logic [22:0] e_iexe(input logic [2:0] a);
    return mk(4'd8, 0,0,0,0,0, 2'd0,2'd0, 0,1, 2'd2, a, 2'd0, 0);
  endfunction
  function automatic logic [22:0] e_iwb();  return mk(4'd9, 0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 3'b000, 2'd0, 0); endfunction
  function automatic logic [22:0] e_br(input logic p);
    return mk(4'd10, p,0,0,0,0, 2'd0,2'd0, 0,1, 2'd0, 3'b001, 2'd1, 0);
  endfunction
  function automatic logic [22:0] e_j();    return mk(4'd11, 1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'b000, 2'd2, 0); endfunction
  function automatic logic [22:0] e_jal();  return mk(4'd12, 1,0,0,0,0, 2'd2,2'd2, 1,0, 2'd0, 3'b000, 2'd2, 0); endfunction
  function automatic logic [22:0] e_jr();   return mk(4'd13, 1,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 3'b000, 2'd3, 0); endfunction

  task automatic add(input logic [5:0] op, fn, input logic z, r, input logic [22:0] exp,
                     input string nm);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.r = r; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic check(input logic [22:0] want, input string nm);
    vec_cnt++;
    if (act !== want) begin
      miss_cnt++;
      $display("FAIL %s: got state=%0d ctl=%h, want state=%0d ctl=%h",
               nm, act[22:19], act[18:0], want[22:19], want[18:0]);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
  task automatic step(input logic [5:0] op, fn, input logic z, r, input logic [22:0] exp,
                      input string nm);
    logic [22:0] e;
    string       n;
    OP = op; Funct = fn; Zero = z; MemReady = r;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check(e, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; OP = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;

    // LW, SW, R-type, JR
    add(6'h23, 0, 0, 1, e_fetch(1), "lw_fetch");
    add(6'h23, 0, 0, 1, e_dec(0),   "lw_decode");
    add(6'h23, 0, 0, 1, e_ma(),     "lw_memadr");
    add(6'h23, 0, 0, 1, e_mr(),     "lw_memrd");
    add(6'h23, 0, 0, 1, e_mwb(),    "lw_memwb");
    add(6'h2b, 0, 0, 1, e_fetch(1), "sw_fetch");
    add(6'h2b, 0, 0, 1, e_dec(0),   "sw_decode");
    add(6'h2b, 0, 0, 1, e_ma(),     "sw_memadr");
    add(6'h2b, 0, 0, 1, e_mw(),     "sw_memwr");
    add(6'h00, 6'h20, 0, 1, e_fetch(1), "add_fetch");
    add(6'h00, 6'h20, 0, 1, e_dec(0),   "add_decode");
    add(6'h00, 6'h20, 0, 1, e_rte(),    "add_rtexe");
    add(6'h00, 6'h20, 0, 1, e_rtwb(),   "add_rtwb");
    add(6'h00, 6'h20, 0, 1, e_fetch(1), "addnr_fetch");
    add(6'h00, 6'h20, 0, 0, e_dec(0),   "addnr_decode");
    add(6'h00, 6'h20, 0, 0, e_rte(),    "addnr_rtexe");
    add(6'h00, 6'h20, 0, 0, e_rtwb(),   "addnr_rtwb");
    add(6'h00, 6'h08, 0, 1, e_fetch(1), "jr_fetch");
    add(6'h00, 6'h08, 0, 1, e_dec(0),   "jr_decode");
    add(6'h00, 6'h08, 0, 1, e_jr(),     "jr_exec");
    // immediates
    add(6'h08, 0, 0, 1, e_fetch(1), "addi_fetch");
    add(6'h08, 0, 0, 1, e_dec(0),   "addi_decode");
    add(6'h08, 0, 0, 1, e_iexe(3'b100), "addi_iexe");
    add(6'h08, 0, 0, 1, e_iwb(),    "addi_iwb");
    add(6'h0d, 0, 0, 1, e_fetch(1), "ori_fetch");
    add(6'h0d, 0, 0, 1, e_dec(0),   "ori_decode");
    add(6'h0d, 0, 0, 1, e_iexe(3'b101), "ori_iexe");
    add(6'h0d, 0, 0, 1, e_iwb(),    "ori_iwb");
    add(6'h0c, 0, 0, 1, e_fetch(1), "andi_fetch");
    add(6'h0c, 0, 0, 1, e_dec(0),   "andi_decode");
    add(6'h0c, 0, 0, 1, e_iexe(3'b110), "andi_iexe");
    add(6'h0c, 0, 0, 1, e_iwb(),    "andi_iwb");
    add(6'h0f, 0, 0, 1, e_fetch(1), "lui_fetch");
    add(6'h0f, 0, 0, 1, e_dec(0),   "lui_decode");
    add(6'h0f, 0, 0, 1, e_iexe(3'b011), "lui_iexe");
    add(6'h0f, 0, 0, 1, e_iwb(),    "lui_iwb");
    // branches and jumps
    add(6'h04, 0, 1, 1, e_fetch(1), "beqt_fetch");
    add(6'h04, 0, 1, 1, e_dec(0),   "beqt_decode");
    add(6'h04, 0, 1, 1, e_br(1),    "beq_zero1");
    add(6'h05, 0, 1, 1, e_fetch(1), "bnef_fetch");
    add(6'h05, 0, 1, 1, e_dec(0),   "bnef_decode");
    add(6'h05, 0, 1, 1, e_br(0),    "bne_zero1");
    add(6'h05, 0, 0, 1, e_fetch(1), "bnet_fetch");
    add(6'h05, 0, 0, 1, e_dec(0),   "bnet_decode");
    add(6'h05, 0, 0, 1, e_br(1),    "bne_zero0");
    add(6'h04, 0, 0, 1, e_fetch(1), "beqf_fetch");
    add(6'h04, 0, 0, 1, e_dec(0),   "beqf_decode");
    add(6'h04, 0, 0, 1, e_br(0),    "beq_zero0");
    add(6'h02, 0, 0, 1, e_fetch(1), "j_fetch");
    add(6'h02, 0, 0, 1, e_dec(0),   "j_decode");
    add(6'h02, 0, 0, 1, e_j(),      "j_exec");
    add(6'h03, 0, 0, 1, e_fetch(1), "jal_fetch");
    add(6'h03, 0, 0, 1, e_dec(0),   "jal_decode");
    add(6'h03, 0, 0, 1, e_jal(),    "jal_exec");
    // SW with three memory wait cycles: 7 cycles total
    add(6'h2b, 0, 0, 1, e_fetch(1), "sws_fetch");
    add(6'h2b, 0, 0, 1, e_dec(0),   "sws_decode");
    add(6'h2b, 0, 0, 1, e_ma(),     "sws_memadr");
    add(6'h2b, 0, 0, 0, e_mw(),     "sws_wait1");
    add(6'h2b, 0, 0, 0, e_mw(),     "sws_wait2");
    add(6'h2b, 0, 0, 0, e_mw(),     "sws_wait3");
    add(6'h2b, 0, 0, 1, e_mw(),     "sws_done");
    // LW with fetch and read stalls
    add(6'h23, 0, 0, 0, e_fetch(0), "lws_fetch_wait");
    add(6'h23, 0, 0, 1, e_fetch(1), "lws_fetch");
    add(6'h23, 0, 0, 1, e_dec(0),   "lws_decode");
    add(6'h23, 0, 0, 1, e_ma(),     "lws_memadr");
    add(6'h23, 0, 0, 0, e_mr(),     "lws_rd_wait");
    add(6'h23, 0, 0, 1, e_mr(),     "lws_memrd");
    add(6'h23, 0, 0, 1, e_mwb(),    "lws_memwb");
    // undefined opcode: one Illegal pulse, back to FETCH with no side effects
    add(6'h3f, 0, 0, 1, e_fetch(1), "ill_fetch");
    add(6'h3f, 0, 0, 1, e_dec(1),   "ill_decode");
    add(6'h3f, 0, 0, 0, e_fetch(0), "ill_refetch_wait");
    add(6'h00, 6'h20, 0, 1, e_fetch(1), "ill_refetch");
    add(6'h00, 6'h20, 0, 1, e_dec(0),   "ill_next_decode");
    add(6'h00, 6'h20, 0, 1, e_rte(),    "ill_next_rtexe");
    add(6'h00, 6'h20, 0, 1, e_rtwb(),   "ill_next_rtwb");

    // reset state, with MemReady high to show outputs are gated
    #2;
    check(23'd0, "reset_outputs");
    @(posedge clk); #1;
    check(23'd0, "reset_outputs_2");
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].r, tbl[i].exp, tbl[i].nm);

    // reset asserted while a store is waiting on memory
    step(6'h2b, 0, 0, 1, e_fetch(1), "rsw_fetch");
    step(6'h2b, 0, 0, 1, e_dec(0),   "rsw_decode");
    step(6'h2b, 0, 0, 1, e_ma(),     "rsw_memadr");
    step(6'h2b, 0, 0, 0, e_mw(),     "rsw_wait");
    MemReady = 1'b0;
    reset    = 1'b0;
    #1;
    watch = 1'b1;
    check(23'd0, "rst_in_memwr");
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    check(23'd0, "rst_in_memwr_rdy");
    @(posedge clk); #1;
    check(23'd0, "rst_held");
    reset = 1'b1;
    step(6'h00, 6'h20, 0, 1, e_fetch(1), "post_rst_fetch");
    step(6'h00, 6'h20, 0, 1, e_dec(0),   "post_rst_decode");
    step(6'h00, 6'h20, 0, 1, e_rte(),    "post_rst_rtexe");
    step(6'h00, 6'h20, 0, 1, e_rtwb(),   "post_rst_rtwb");
    watch = 1'b0;
    vec_cnt++;
    if (mw_seen !== 1'b0) begin
      miss_cnt++;
      $display("FAIL no_memwrite_after_reset: got MemWrite seen=%b, want 0", mw_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
